// File: rtl/cascade_time_counter_pkg.sv
// Shared definitions for the cascaded time counter: default moduli, direction
// encoding and the floored clog2 used to size every stage.
package timer_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int unsigned SEC_MOD_DEFAULT = 60;
    localparam int unsigned MIN_MOD_DEFAULT = 60;
    localparam int unsigned HR_MOD_DEFAULT  = 24;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int unsigned clog2w(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/cascade_time_counter_mod_counter.sv
// One modulo stage of the time chain: up/down wrap, saturating parallel load,
// and a combinational carry/borrow for the stage above.
module mod_counter
    import timer_pkg::*;
#(
    parameter  int unsigned MOD = 60,
    localparam int unsigned W   = clog2w(MOD)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         dir,
    input  logic         hold,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         carry
);

    localparam logic [W-1:0] MAX = W'(MOD - 1);

    logic         step;
    logic         at_end;
    logic [W-1:0] load_sat;

    always_comb begin
        step     = en && !hold && !clear && !load && rst_n;
        at_end   = (dir == DIR_DOWN) ? (count == '0) : (count == MAX);
        carry    = step && at_end;
        load_sat = (load_val > MAX) ? MAX : load_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_sat;
        end else if (step) begin
            if (dir == DIR_DOWN) begin
                count <= (count == '0) ? MAX : count - 1'b1;
            end else begin
                count <= (count == MAX) ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cascade_time_counter.sv
// Hours:minutes:seconds counter built from three cascaded mod_counter stages,
// with count-down, load, clear and an optional stop-at-zero expiry flag.
module cascade_time_counter
    import timer_pkg::*;
#(
    parameter  int unsigned SEC_MOD      = SEC_MOD_DEFAULT,
    parameter  int unsigned MIN_MOD      = MIN_MOD_DEFAULT,
    parameter  int unsigned HR_MOD       = HR_MOD_DEFAULT,
    parameter  bit          STOP_AT_ZERO = 1'b1,
    localparam int unsigned SW           = clog2w(SEC_MOD),
    localparam int unsigned MW           = clog2w(MIN_MOD),
    localparam int unsigned HW           = clog2w(HR_MOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          dir,
    input  logic          clear,
    input  logic          load,
    input  logic [SW-1:0] load_sec,
    input  logic [MW-1:0] load_min,
    input  logic [HW-1:0] load_hr,
    output logic [SW-1:0] seconds,
    output logic [MW-1:0] minutes,
    output logic [HW-1:0] hours,
    output logic          sec_carry,
    output logic          min_carry,
    output logic          rollover,
    output logic          expired
);

    logic down;
    logic tick_ok;
    logic at_zero;
    logic hold;
    logic last_down;
    logic sec_c;
    logic min_c;
    logic hr_c;

    always_comb begin
        down      = (dir == DIR_DOWN);
        tick_ok   = tick && rst_n && !clear && !load;
        at_zero   = (seconds == '0) && (minutes == '0) && (hours == '0);
        hold      = STOP_AT_ZERO && down && at_zero;
        // A down tick lands on 0:0:0 either from 0:0:1 or by holding there.
        last_down = down && (hours == '0) && (minutes == '0) &&
                    ((seconds == SW'(1)) || (seconds == '0));
    end

    mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tick_ok),
        .dir      (dir),
        .hold     (hold),
        .clear    (clear),
        .load     (load),
        .load_val (load_sec),
        .count    (seconds),
        .carry    (sec_c)
    );

    mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (sec_c),
        .dir      (dir),
        .hold     (hold),
        .clear    (clear),
        .load     (load),
        .load_val (load_min),
        .count    (minutes),
        .carry    (min_c)
    );

    mod_counter #(.MOD(HR_MOD)) u_hr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (min_c),
        .dir      (dir),
        .hold     (hold),
        .clear    (clear),
        .load     (load),
        .load_val (load_hr),
        .count    (hours),
        .carry    (hr_c)
    );

    always_comb begin
        sec_carry = sec_c;
        min_carry = min_c;
        rollover  = hr_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            expired <= 1'b0;
        end else if (clear || load) begin
            expired <= 1'b0;
        end else if (STOP_AT_ZERO && tick_ok && last_down) begin
            expired <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cascade_time_counter.sv
// Scoreboard bench for cascade_time_counter: three instances (60/60/24 stop,
// 60/60/24 wrap, 10/6/2 wrap) checked against an arithmetic time model.
module tb_cascade_time_counter;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       ex;
        logic       sc;
        logic       mc;
        logic       ro;
    } result_t;

    logic clk;
    logic rst_n;

    logic       a_tick, a_dir, a_clear, a_load;
    logic [5:0] a_load_sec, a_load_min;
    logic [4:0] a_load_hr;
    logic [5:0] a_seconds, a_minutes;
    logic [4:0] a_hours;
    logic       a_sec_carry, a_min_carry, a_rollover, a_expired;

    logic       b_tick, b_dir, b_clear, b_load;
    logic [5:0] b_load_sec, b_load_min;
    logic [4:0] b_load_hr;
    logic [5:0] b_seconds, b_minutes;
    logic [4:0] b_hours;
    logic       b_sec_carry, b_min_carry, b_rollover, b_expired;

    logic       c_tick, c_dir, c_clear, c_load;
    logic [3:0] c_load_sec;
    logic [2:0] c_load_min;
    logic [0:0] c_load_hr;
    logic [3:0] c_seconds;
    logic [2:0] c_minutes;
    logic [0:0] c_hours;
    logic       c_sec_carry, c_min_carry, c_rollover, c_expired;

    cascade_time_counter #(.SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24), .STOP_AT_ZERO(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(a_tick), .dir(a_dir), .clear(a_clear), .load(a_load),
        .load_sec(a_load_sec), .load_min(a_load_min), .load_hr(a_load_hr),
        .seconds(a_seconds), .minutes(a_minutes), .hours(a_hours),
        .sec_carry(a_sec_carry), .min_carry(a_min_carry), .rollover(a_rollover), .expired(a_expired)
    );

    cascade_time_counter #(.SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24), .STOP_AT_ZERO(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(b_tick), .dir(b_dir), .clear(b_clear), .load(b_load),
        .load_sec(b_load_sec), .load_min(b_load_min), .load_hr(b_load_hr),
        .seconds(b_seconds), .minutes(b_minutes), .hours(b_hours),
        .sec_carry(b_sec_carry), .min_carry(b_min_carry), .rollover(b_rollover), .expired(b_expired)
    );

    cascade_time_counter #(.SEC_MOD(10), .MIN_MOD(6), .HR_MOD(2), .STOP_AT_ZERO(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .tick(c_tick), .dir(c_dir), .clear(c_clear), .load(c_load),
        .load_sec(c_load_sec), .load_min(c_load_min), .load_hr(c_load_hr),
        .seconds(c_seconds), .minutes(c_minutes), .hours(c_hours),
        .sec_carry(c_sec_carry), .min_carry(c_min_carry), .rollover(c_rollover), .expired(c_expired)
    );

    int smod[3] = '{60, 60, 10};
    int mmod[3] = '{60, 60, 6};
    int hmod[3] = '{24, 24, 2};
    int wsec[3] = '{6, 6, 4};
    int wmin[3] = '{6, 6, 3};
    int whr[3]  = '{5, 5, 1};
    bit stopv[3] = '{1'b1, 1'b0, 1'b0};

    int ms[3];
    int mm[3];
    int mh[3];
    bit mex[3];

    result_t exp_q[$];
    result_t exp_r;
    result_t obs_r;
    logic    cap_sc, cap_mc, cap_ro;
    int      n_cmp = 0;
    int      n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no summary by time limit, want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic string fmt(input result_t r);
        return $sformatf("%0d:%0d:%0d ex=%b sc=%b mc=%b ro=%b", r.h, r.m, r.s, r.ex, r.sc, r.mc, r.ro);
    endfunction

    function automatic result_t observe(input int d);
        result_t r;
        r = '0;
        case (d)
            0: begin r.s = 8'(a_seconds); r.m = 8'(a_minutes); r.h = 8'(a_hours); r.ex = a_expired; end
            1: begin r.s = 8'(b_seconds); r.m = 8'(b_minutes); r.h = 8'(b_hours); r.ex = b_expired; end
            default: begin r.s = 8'(c_seconds); r.m = 8'(c_minutes); r.h = 8'(c_hours); r.ex = c_expired; end
        endcase
        r.sc = cap_sc;
        r.mc = cap_mc;
        r.ro = cap_ro;
        return r;
    endfunction

    // Reference: treat the count as a single number of seconds modulo the full period.
    task automatic model_step(input int d, input bit rst, input bit clr, input bit ld, input bit tk,
                              input bit dr, input int ls, input int lm, input int lh, output result_t r);
        int sm, mo, hm, n, tot, v;
        int ns, nm, nh;
        bit e;
        sm = smod[d]; mo = mmod[d]; hm = hmod[d];
        n  = sm * mo * hm;
        r  = '0;
        ns = ms[d]; nm = mm[d]; nh = mh[d]; e = mex[d];
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                ms[k] = 0; mm[k] = 0; mh[k] = 0; mex[k] = 1'b0;
            end
            ns = 0; nm = 0; nh = 0; e = 1'b0;
        end else if (clr) begin
            ns = 0; nm = 0; nh = 0; e = 1'b0;
        end else if (ld) begin
            v  = ls & ((1 << wsec[d]) - 1); ns = (v > sm - 1) ? sm - 1 : v;
            v  = lm & ((1 << wmin[d]) - 1); nm = (v > mo - 1) ? mo - 1 : v;
            v  = lh & ((1 << whr[d]) - 1);  nh = (v > hm - 1) ? hm - 1 : v;
            e  = 1'b0;
        end else if (tk) begin
            tot = mh[d] * mo * sm + mm[d] * sm + ms[d];
            if (!dr) begin
                r.sc = (ms[d] == sm - 1);
                r.mc = r.sc && (mm[d] == mo - 1);
                r.ro = (tot == n - 1);
                tot  = (tot + 1) % n;
            end else if (tot == 0 && stopv[d]) begin
                e = 1'b1;
            end else begin
                r.sc = (ms[d] == 0);
                r.mc = r.sc && (mm[d] == 0);
                r.ro = (tot == 0);
                tot  = (tot + n - 1) % n;
                if (stopv[d] && tot == 0) e = 1'b1;
            end
            ns = tot % sm;
            nm = (tot / sm) % mo;
            nh = tot / (sm * mo);
        end
        ms[d] = ns; mm[d] = nm; mh[d] = nh; mex[d] = e;
        r.s = 8'(ns); r.m = 8'(nm); r.h = 8'(nh); r.ex = e;
    endtask

    // Drive one cycle on instance d, capture carries before the edge, queue the expectation.
    task automatic drive(input int d, input bit rst, input bit clr, input bit ld, input bit tk,
                         input bit dr, input int ls, input int lm, input int lh);
        result_t r;
        a_tick = 0; a_dir = 0; a_clear = 0; a_load = 0; a_load_sec = '0; a_load_min = '0; a_load_hr = '0;
        b_tick = 0; b_dir = 0; b_clear = 0; b_load = 0; b_load_sec = '0; b_load_min = '0; b_load_hr = '0;
        c_tick = 0; c_dir = 0; c_clear = 0; c_load = 0; c_load_sec = '0; c_load_min = '0; c_load_hr = '0;
        rst_n = !rst;
        case (d)
            0: begin a_tick = tk; a_dir = dr; a_clear = clr; a_load = ld;
                     a_load_sec = 6'(ls); a_load_min = 6'(lm); a_load_hr = 5'(lh); end
            1: begin b_tick = tk; b_dir = dr; b_clear = clr; b_load = ld;
                     b_load_sec = 6'(ls); b_load_min = 6'(lm); b_load_hr = 5'(lh); end
            default: begin c_tick = tk; c_dir = dr; c_clear = clr; c_load = ld;
                     c_load_sec = 4'(ls); c_load_min = 3'(lm); c_load_hr = 1'(lh); end
        endcase
        #1;
        case (d)
            0: begin cap_sc = a_sec_carry; cap_mc = a_min_carry; cap_ro = a_rollover; end
            1: begin cap_sc = b_sec_carry; cap_mc = b_min_carry; cap_ro = b_rollover; end
            default: begin cap_sc = c_sec_carry; cap_mc = c_min_carry; cap_ro = c_rollover; end
        endcase
        model_step(d, rst, clr, ld, tk, dr, ls, lm, lh, r);
        exp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            drive(d, 1, 0, 1, 1, 0, 5, 5, 1);
            exp_r = exp_q.pop_front(); obs_r = observe(d); n_cmp++;
            if (obs_r !== exp_r) begin
                n_err++;
                $display("FAIL reset[%0d]: got %s, want %s", d, fmt(obs_r), fmt(exp_r));
            end
        end
    endtask

    task automatic test_count_up();
        for (int i = 0; i < 61; i++) begin
            drive(0, 0, 0, 0, (i < 60), 0, 0, 0, 0);
            exp_r = exp_q.pop_front(); obs_r = observe(0); n_cmp++;
            if (obs_r !== exp_r) begin
                n_err++;
                $display("FAIL count_up[%0d]: got %s, want %s", i, fmt(obs_r), fmt(exp_r));
            end
        end
    endtask

    task automatic test_load_priority();
        // {clr, ld, tk, dir, sec, min, hr}
        int steps[8][7] = '{
            '{0, 1, 0, 0, 59, 59, 23},
            '{0, 0, 1, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0},
            '{0, 1, 0, 0, 63, 63, 31},
            '{0, 1, 1, 0, 3, 2, 1},
            '{0, 1, 0, 0, 59, 59, 23},
            '{1, 1, 1, 0, 7, 7, 7},
            '{0, 0, 1, 1, 0, 0, 0}
        };
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, steps[i][0] != 0, steps[i][1] != 0, steps[i][2] != 0, steps[i][3] != 0,
                  steps[i][4], steps[i][5], steps[i][6]);
            exp_r = exp_q.pop_front(); obs_r = observe(1); n_cmp++;
            if (obs_r !== exp_r) begin
                n_err++;
                $display("FAIL load_priority[%0d]: got %s, want %s", i, fmt(obs_r), fmt(exp_r));
            end
        end
    endtask

    task automatic test_stop_at_zero();
        // {clr, ld, tk, dir, sec}
        int steps[10][5] = '{
            '{0, 1, 0, 1, 2},
            '{0, 0, 1, 1, 0},
            '{0, 0, 1, 1, 0},
            '{0, 0, 1, 1, 0},
            '{0, 0, 0, 1, 0},
            '{0, 0, 1, 0, 0},
            '{0, 0, 1, 1, 0},
            '{0, 0, 1, 1, 0},
            '{1, 0, 0, 0, 0},
            '{0, 0, 1, 1, 0}
        };
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, steps[i][0] != 0, steps[i][1] != 0, steps[i][2] != 0, steps[i][3] != 0,
                  steps[i][4], 0, 0);
            exp_r = exp_q.pop_front(); obs_r = observe(0); n_cmp++;
            if (obs_r !== exp_r) begin
                n_err++;
                $display("FAIL stop_at_zero[%0d]: got %s, want %s", i, fmt(obs_r), fmt(exp_r));
            end
        end
    endtask

    task automatic test_wrap_down();
        int steps[5][5] = '{
            '{1, 0, 0, 1, 0},
            '{0, 1, 1, 0, 0},
            '{1, 0, 0, 0, 0},
            '{0, 1, 1, 0, 0},
            '{0, 1, 1, 0, 0}
        };
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, steps[i][0] != 0, steps[i][1] != 0, steps[i][2] != 0,
                  steps[i][4], steps[i][3], 0);
            exp_r = exp_q.pop_front(); obs_r = observe(1); n_cmp++;
            if (obs_r !== exp_r) begin
                n_err++;
                $display("FAIL wrap_down[%0d]: got %s, want %s", i, fmt(obs_r), fmt(exp_r));
            end
        end
    endtask

    task automatic test_small_rollover();
        int ro_seen;
        ro_seen = 0;
        drive(2, 0, 1, 0, 0, 0, 0, 0, 0);
        exp_r = exp_q.pop_front(); obs_r = observe(2); n_cmp++;
        if (obs_r !== exp_r) begin
            n_err++;
            $display("FAIL small_clear: got %s, want %s", fmt(obs_r), fmt(exp_r));
        end
        for (int i = 0; i < 120; i++) begin
            drive(2, 0, 0, 0, 1, 0, 0, 0, 0);
            if (cap_ro === 1'b1) ro_seen++;
            exp_r = exp_q.pop_front(); obs_r = observe(2); n_cmp++;
            if (obs_r !== exp_r) begin
                n_err++;
                $display("FAIL small_up[%0d]: got %s, want %s", i, fmt(obs_r), fmt(exp_r));
            end
        end
        n_cmp++;
        if (ro_seen !== 1 || c_seconds !== 4'd0 || c_minutes !== 3'd0 || c_hours !== 1'd0) begin
            n_err++;
            $display("FAIL small_rollover_pulses: got %0d pulses at %0d:%0d:%0d, want 1 pulse at 0:0:0",
                     ro_seen, c_hours, c_minutes, c_seconds);
        end
    endtask

    task automatic test_dir_toggle();
        for (int i = 0; i < 80; i++) begin
            bit tk, dr, ld;
            tk = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 1) != 0);
            ld = ($urandom_range(0, 15) == 0);
            drive(2, 0, 0, ld, tk, dr, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1));
            exp_r = exp_q.pop_front(); obs_r = observe(2); n_cmp++;
            if (obs_r !== exp_r) begin
                n_err++;
                $display("FAIL dir_toggle[%0d]: got %s, want %s", i, fmt(obs_r), fmt(exp_r));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 120; i++) begin
            int d;
            bit clr, ld, tk, dr;
            d   = i % 2;
            clr = ($urandom_range(0, 31) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            tk  = ($urandom_range(0, 4) != 0);
            dr  = ($urandom_range(0, 2) != 0);
            // Small loads keep the stop-at-zero corner reachable.
            drive(d, 0, clr, ld, tk, dr, $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 1));
            exp_r = exp_q.pop_front(); obs_r = observe(d); n_cmp++;
            if (obs_r !== exp_r) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %s, want %s", i, fmt(obs_r), fmt(exp_r));
            end
        end
        drive(0, 0, 0, 1, 0, 0, 30, 20, 10);
        exp_r = exp_q.pop_front(); obs_r = observe(0); n_cmp++;
        if (obs_r !== exp_r) begin
            n_err++;
            $display("FAIL mid_load: got %s, want %s", fmt(obs_r), fmt(exp_r));
        end
        drive(0, 1, 0, 1, 1, 1, 9, 9, 9);
        exp_r = exp_q.pop_front(); obs_r = observe(0); n_cmp++;
        if (obs_r !== exp_r) begin
            n_err++;
            $display("FAIL mid_reset: got %s, want %s", fmt(obs_r), fmt(exp_r));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cap_sc = 1'b0; cap_mc = 1'b0; cap_ro = 1'b0;
        a_tick = 0; a_dir = 0; a_clear = 0; a_load = 0; a_load_sec = '0; a_load_min = '0; a_load_hr = '0;
        b_tick = 0; b_dir = 0; b_clear = 0; b_load = 0; b_load_sec = '0; b_load_min = '0; b_load_hr = '0;
        c_tick = 0; c_dir = 0; c_clear = 0; c_load = 0; c_load_sec = '0; c_load_min = '0; c_load_hr = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_count_up();
        test_load_priority();
        test_stop_at_zero();
        test_wrap_down();
        test_small_rollover();
        test_dir_toggle();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cascade_time_counter.md
# cascade_time_counter

Parametrised hours:minutes:seconds counter built from three cascaded modulo stages, advanced by a one-cycle `tick` strobe from the prescaler. It adds count-down mode, parallel load, clear and a stop-at-zero countdown-timer option. It sits between the tick generator and the display/BCD path, and serves both the stopwatch and countdown-timer top levels.

## Interface
- `SEC_MOD`, 60: seconds stage modulus (≥2)
- `MIN_MOD`, 60: minutes stage modulus (≥2)
- `HR_MOD`, 24: hours stage modulus (≥2)
- `STOP_AT_ZERO`, 1: down mode holds at 0:0:0 and flags expiry (1), or wraps to max (0)
- Derived widths: `SW`=clog2(SEC_MOD), `MW`=clog2(MIN_MOD), `HW`=clog2(HR_MOD), each minimum 1
- `clk` in 1: single clock, all logic on posedge
- `rst_n` in 1: reset, synchronous, active-low
- `tick` in 1: one-cycle count strobe
- `dir` in 1: 0 = count up, 1 = count down
- `clear` in 1: synchronous zero of all stages, clears `expired`
- `load` in 1: parallel load strobe
- `load_sec` in SW: seconds value for load
- `load_min` in MW: minutes value for load
- `load_hr` in HW: hours value for load
- `seconds` out SW: seconds count, registered
- `minutes` out MW: minutes count, registered
- `hours` out HW: hours count, registered
- `sec_carry` out 1: combinational; seconds stage wraps on this edge
- `min_carry` out 1: combinational; minutes stage wraps on this edge
- `rollover` out 1: combinational; full-chain wrap on this edge (00:00:00 ↔ max)
- `expired` out 1: registered, sticky; countdown reached 0:0:0 with STOP_AT_ZERO=1

## Operation
- Priority on each edge: `!rst_n` > `clear` > `load` > `tick`. Lower-priority inputs in the same cycle are ignored.
- Reset or clear: all counts 0, `expired` 0.
- Load: each field is stored independently. A value ≥ its modulus saturates to modulus−1. Load clears `expired`.
- Up, on tick:
  - seconds +1; at SEC_MOD−1 it wraps to 0 and asserts `sec_carry`.
  - minutes advance only on `sec_carry`, with the same rule, asserting `min_carry`.
  - hours advance only on `min_carry`; at HR_MOD−1 they wrap to 0. `rollover` = tick && all three stages at max.
- Down, on tick:
  - seconds −1; at 0 it wraps to SEC_MOD−1 and asserts `sec_carry` (borrow). Minutes and hours borrow the same way.
  - Transition from 0:0:0: with STOP_AT_ZERO=0, wraps to all-max and asserts `rollover`. With STOP_AT_ZERO=1, counts hold, carries and `rollover` stay 0.
  - With STOP_AT_ZERO=1, `expired` sets on the edge where a down tick leaves the count at 0:0:0, including 0:0:1 → 0:0:0. Further down ticks hold. An up tick from 0:0:0 counts normally and does not clear `expired`.
- Carry outputs are combinational functions of the current count, `tick` and `dir`. They are gated low whenever `clear`, `load` or `!rst_n` is active.
- `dir` is sampled per tick; changing it between ticks needs no settling.
- `tick` held high counts on every cycle; there is no edge detection.

## Timing
- Latency: counts update on the edge where `tick` is high and are visible the next cycle.
- `sec_carry`, `min_carry` and `rollover` are valid in the same cycle as the causing tick, before the edge. They are intended for cascading further blocks on the same tick.
- `expired` is visible the cycle after the terminal edge.
- Reset values: `seconds`=`minutes`=`hours`=0, `expired`=0, all carries 0.
- Reset mid-count takes effect at the next edge regardless of `tick`, `load` or `clear`.

## Structure
- Shared package/header `timer_pkg`:
  - clog2 width function, floored at 1
  - default moduli constants (60, 60, 24)
  - `DIR_UP`/`DIR_DOWN` encodings
- One sub-module, `mod_counter`, instantiated three times:
  - parameter: `MOD`
  - inputs: `clk`, `rst_n`, `en`, `dir`, `hold`, `clear`, `load`, `load_val`
  - outputs: `count`, `carry`
  - `load_val` saturation and wrap logic live in `mod_counter`.
- Top level: enable chaining, zero/stop detection, `expired` register.

## Test plan
- Reset with `tick`=1, `load`=1 → all counts 0, `expired`=0. After release, 59 up ticks → seconds=59; next tick → seconds=0, minutes=1, `sec_carry` high for exactly that cycle.
- Load 23:59:59 with dir=0, one tick → 00:00:00, `rollover`=1 for that cycle. Load 75:70:99 (widths permitting) → saturates to 23:59:59.
- STOP_AT_ZERO=1: load 0:0:2, dir=1, three ticks → 0:0:1, 0:0:0, hold. `expired` goes to 1 the cycle after reaching 0 and stays high. `clear` → `expired`=0.
- STOP_AT_ZERO=0: count down from 0:1:0 → 0:0:59 with `sec_carry`=1. Down tick from 0:0:0 → 23:59:59 with `rollover`=1.
- Same cycle `clear`=1, `load`=1, `tick`=1 → 00:00:00, no carries. Same cycle `load`+`tick` → loaded value, not loaded+1.
- SEC_MOD=10, MIN_MOD=6, HR_MOD=2 instance: 120 up ticks → back to 0:0:0 with exactly one `rollover` pulse. Toggling `dir` between ticks reverses the count with no lost tick.
